// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode/funct3 constants, ALU operation enum and funct decode helper
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    // ADDI has no subtract form, so the alternate bit only selects SUB for register ops
    function automatic alu_op_t decode_funct(input logic [2:0] f3, input logic alt,
                                             input logic allow_sub);
        case (f3)
            F3_ADD:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational RV32I integer ALU
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_op,
    output logic [WIDTH-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_top.sv
// rtl/riscv_top.sv - single-cycle RV32I execute core: decoder, immediates, register file
module riscv_top
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] regs [32];

    logic [6:0]       opcode;
    logic [4:0]       dst;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       f3;
    logic             alt;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    alu_op_t          alu_op;
    logic             valid;

    assign opcode = addr[6:0];
    assign dst    = addr[11:7];
    assign f3     = addr[14:12];
    assign rs1    = addr[19:15];
    assign rs2    = addr[24:20];
    assign alt    = addr[30];
    assign imm_i  = {{(WIDTH-12){addr[31]}}, addr[31:20]};
    assign imm_u  = {addr[31:12], 12'b0};

    // x0 is forced to zero on read; its storage slot is never written
    assign op_a     = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign op_b_reg = (rs2 == 5'd0) ? '0 : regs[rs2];

    always_comb begin
        valid  = 1'b0;
        alu_op = ALU_ADD;
        op_b   = op_b_reg;
        case (opcode)
            OPC_OP: begin
                valid  = 1'b1;
                alu_op = decode_funct(f3, alt, 1'b1);
            end
            OPC_OP_IMM: begin
                valid  = 1'b1;
                alu_op = decode_funct(f3, alt, 1'b0);
                op_b   = imm_i;
            end
            OPC_LUI: begin
                valid  = 1'b1;
                alu_op = ALU_PASSB;
                op_b   = imm_u;
            end
            default: valid = 1'b0;
        endcase
    end

    riscv_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (alu_op),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (valid) begin
            rd <= result;
            if (dst != 5'd0) begin
                regs[dst] <= result;
            end
        end
    end

endmodule

// File: tb/tb_riscv_top.sv
// tb/tb_riscv_top.sv - self-checking bench for riscv_top with directed and random instructions
module tb_riscv_top;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rd;

    int checks;
    int errors;

    logic [31:0] model_regs [32];
    logic [31:0] model_rd;

    riscv_top #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .rd   (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] fn,
                                           input logic [4:0] d);
        return {f7, s2, s1, fn, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                           input logic [2:0] fn, input logic [4:0] d);
        return {imm, s1, fn, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_lui(input logic [19:0] imm, input logic [4:0] d);
        return {imm, d, 7'b0110111};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_rd = 32'd0;
    endtask

    // Architectural meaning of one instruction, applied to the bench's own register array
    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, res;
        logic [4:0]  sh;
        logic        ok;
        a  = model_regs[ins[19:15]];
        ok = 1'b1;
        if (ins[6:0] == 7'b0110011) b = model_regs[ins[24:20]];
        else b = {{20{ins[31]}}, ins[31:20]};
        sh = b[4:0];
        res = 32'd0;
        case (ins[6:0])
            7'b0110011, 7'b0010011: begin
                case (ins[14:12])
                    3'd0: res = (ins[6:0] == 7'b0110011 && ins[30]) ? a - b : a + b;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            7'b0110111: res = {ins[31:12], 12'd0};
            default: ok = 1'b0;
        endcase
        if (ok) begin
            model_rd = res;
            if (ins[11:7] != 5'd0) model_regs[ins[11:7]] = res;
        end
    endtask

    // Present one instruction across a rising edge and sample just after it
    task automatic step(input logic [31:0] ins);
        addr = ins;
        @(posedge clk);
        #1;
        model_exec(ins);
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        addr = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd: got %h expected %h", rd, 32'd0);
        end
        #2 rst = 1'b1;
        step(r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd5));
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_add_x0: got %h expected %h", rd, 32'd0);
        end
        for (int r = 1; r < 32; r++) begin
            step(i_type(12'd0, r[4:0], 3'd0, r[4:0]));
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg_x%0d: got %h expected %h", r, rd, 32'd0);
            end
        end
    endtask

    task automatic test_addi_add();
        logic [31:0] prog [3];
        logic [31:0] exp_v [3];
        prog[0] = 32'h00A08093; exp_v[0] = 32'd10;
        prog[1] = 32'h00A10113; exp_v[1] = 32'd10;
        prog[2] = 32'h001101B3; exp_v[2] = 32'd20;
        for (int i = 0; i < 3; i++) begin
            step(prog[i]);
            checks++;
            if (rd !== exp_v[i]) begin
                errors++;
                $display("FAIL addi_add_%0d: got %h expected %h", i, rd, exp_v[i]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [31:0] prog [3];
        logic [31:0] exp_v [3];
        prog[0] = 32'hFFF00213;                    exp_v[0] = 32'hFFFFFFFF;
        prog[1] = i_type(12'h404, 5'd4, 3'd5, 5'd5); exp_v[1] = 32'hFFFFFFFF;
        prog[2] = i_type(12'd28, 5'd4, 3'd5, 5'd6);  exp_v[2] = 32'h0000000F;
        for (int i = 0; i < 3; i++) begin
            step(prog[i]);
            checks++;
            if (rd !== exp_v[i]) begin
                errors++;
                $display("FAIL shifts_%0d: got %h expected %h", i, rd, exp_v[i]);
            end
        end
    endtask

    task automatic test_compare_lui();
        logic [31:0] prog [4];
        logic [31:0] exp_v [4];
        prog[0] = r_type(7'd0, 5'd1, 5'd4, 3'd2, 5'd7);     exp_v[0] = 32'd1;
        prog[1] = r_type(7'd0, 5'd1, 5'd4, 3'd3, 5'd7);     exp_v[1] = 32'd0;
        prog[2] = r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd8);    exp_v[2] = 32'd0;
        prog[3] = u_lui(20'h12345, 5'd9);                   exp_v[3] = 32'h12345000;
        for (int i = 0; i < 4; i++) begin
            step(prog[i]);
            checks++;
            if (rd !== exp_v[i]) begin
                errors++;
                $display("FAIL cmp_lui_%0d: got %h expected %h", i, rd, exp_v[i]);
            end
        end
    endtask

    task automatic test_x0_nop();
        step(i_type(12'd5, 5'd0, 3'd0, 5'd0));
        checks++;
        if (rd !== 32'd5) begin
            errors++;
            $display("FAIL x0_write_rd: got %h expected %h", rd, 32'd5);
        end
        step(r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd10));
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL x0_reads_zero: got %h expected %h", rd, 32'd0);
        end
        step(u_lui(20'hABCDE, 5'd11));
        step(32'h00000000);
        checks++;
        if (rd !== 32'hABCDE000) begin
            errors++;
            $display("FAIL nop_hold: got %h expected %h", rd, 32'hABCDE000);
        end
        for (int r = 1; r < 12; r++) begin
            step(i_type(12'd0, r[4:0], 3'd0, 5'd0));
            checks++;
            if (rd !== model_regs[r]) begin
                errors++;
                $display("FAIL nop_reg_x%0d: got %h expected %h", r, rd, model_regs[r]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  opc;
        logic [2:0]  fn;
        for (int n = 0; n < 400; n++) begin
            fn = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ins = r_type(((fn == 3'd0 || fn == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                5'($urandom), 5'($urandom), fn, 5'($urandom));
                1: begin
                    if (fn == 3'd1)
                        ins = i_type({7'h00, 5'($urandom)}, 5'($urandom), fn, 5'($urandom));
                    else if (fn == 3'd5)
                        ins = i_type({($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)},
                                     5'($urandom), fn, 5'($urandom));
                    else
                        ins = i_type(12'($urandom), 5'($urandom), fn, 5'($urandom));
                end
                2: ins = u_lui(20'($urandom), 5'($urandom));
                default: begin
                    opc = 7'($urandom);
                    while (opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b0110111)
                        opc = 7'($urandom);
                    ins = {25'($urandom), opc};
                end
            endcase
            step(ins);
            checks++;
            if (rd !== model_rd) begin
                errors++;
                $display("FAIL random_%0d ins=%h: got %h expected %h", n, ins, rd, model_rd);
            end
        end
        for (int r = 0; r < 32; r++) begin
            step(i_type(12'd0, r[4:0], 3'd0, 5'd0));
            checks++;
            if (rd !== model_regs[r]) begin
                errors++;
                $display("FAIL random_reg_x%0d: got %h expected %h", r, rd, model_regs[r]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(i_type(12'd7, 5'd0, 3'd0, 5'd11));
        checks++;
        if (rd !== 32'd7) begin
            errors++;
            $display("FAIL pre_reset_rd: got %h expected %h", rd, 32'd7);
        end
        addr = i_type(12'd99, 5'd0, 3'd0, 5'd1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_rd: got %h expected %h", rd, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        step(32'h001101B3);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_add: got %h expected %h", rd, 32'd0);
        end
        step(i_type(12'd0, 5'd1, 3'd0, 5'd0));
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_x1: got %h expected %h", rd, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        addr   = 32'd0;
        test_reset();
        test_addi_add();
        test_shifts();
        test_compare_lui();
        test_x0_nop();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
